ready_sync_picker: RTL and testbench
====================================

Name: ready_sync_picker

Overview:
Parametrised N-player ready gate and pseudo-random number picker for the factorization game front end. It debounces each player's ready button and free-runs a tick-driven modulo counter. When every player has signalled ready, it latches the counter value as the round number and holds it until game logic acknowledges with OK. It adds a partial-ready timeout and a status vector that the earlier two-player gate lacked.

Parameters:
NUM_PLAYERS, 2, number of ready inputs (1..8)
CLK_HZ, 50_000_000, CLK frequency
TICK_HZ, 1, tick rate; DIV = CLK_HZ/TICK_HZ clock cycles per tick (DIV >= 2)
NUM_MOD, 10, counter modulus; NUM cycles 0..NUM_MOD-1
NUM_W, 4, width of NUM; must satisfy 2^NUM_W >= NUM_MOD
DEB_CYC, 16, cycles a synchronised input must be stable before its debounced level changes
TIMEOUT_TICKS, 30, ticks allowed between first and last ready; 0 disables the timeout

Ports:
CLK  in  1  clock
RST  in  1  reset; synchronous, active-high
READY_IN  in  NUM_PLAYERS  raw ready buttons, active-high, asynchronous to CLK
OK  in  1  round acknowledge from game logic, level-sampled
TICK  out  1  one-cycle pulse at TICK_HZ
NUM  out  NUM_W  latched round number
RUN_IN  out  1  one-cycle pulse in the cycle NUM is updated
VALID  out  1  high while NUM holds an unacknowledged round value
READY_SEEN  out  NUM_PLAYERS  sticky per-player ready flags for the current round
TIMEOUT  out  1  one-cycle pulse when partial ready is abandoned

Behaviour:
- Reset values: all outputs 0; divider, sec counter, timeout counter and debounce counters 0; debounced levels 0; state ARMED.
- Divider: cnt counts 0..DIV-1 and wraps. TICK=1 in the cycle cnt==DIV-1.
- Sec counter: advances on TICK from 0 to NUM_MOD-1, then wraps to 0. It runs in every state.
- Input path per channel: two-flop synchroniser, then debounce. The debounce counter resets whenever the synchronised value differs from the debounced level. The debounced level takes the new value after DEB_CYC consecutive differing cycles. A rising edge of the debounced level is a press.
- State machine:
  - ARMED: a press on channel i sets READY_SEEN[i], which stays set until cleared. When all bits are set, including bits set this cycle, go to LATCH.
  - LATCH (one cycle): NUM <= sec, using the register value this cycle, before any same-cycle tick increment. RUN_IN=1. VALID<=1. Go to HOLD.
  - HOLD: NUM is frozen. Presses are ignored. When OK=1, READY_SEEN<=0 and VALID<=0, then go to ARMED.
- OK is ignored outside HOLD. Holding OK high continuously causes exactly one return to ARMED per round.
- Timeout (TIMEOUT_TICKS>0):
  - In ARMED, with READY_SEEN nonzero and not all ones, the timeout counter increments on each TICK.
  - When the counter reaches TIMEOUT_TICKS: TIMEOUT pulses, READY_SEEN<=0, counter<=0, state stays ARMED.
  - The counter clears whenever READY_SEEN is zero or the state leaves ARMED.
- Simultaneous events:
  - The last press in the same cycle as the timeout expiry: the latch wins and there is no TIMEOUT pulse.
  - Several presses in one cycle: all are recorded.
- NUM_PLAYERS=1: the first press latches immediately.
- RST mid-round: immediate return to reset values. A button held through reset is not a press until it is released and pressed again, because the debounced level restarts at 0 and must rise.

Test Plan:
Common bench parameters: CLK_HZ=10, TICK_HZ=1 (DIV=10), NUM_MOD=10, DEB_CYC=2, TIMEOUT_TICKS=3, NUM_PLAYERS=2.
- Reset then idle 105 cycles -> TICK every 10th cycle. After 10 ticks the sec counter has wrapped to 0. NUM=0, VALID=0, RUN_IN never pulses.
- Press P0 then P1 while sec=7 -> RUN_IN pulses once; NUM=7 and VALID=1. READY_SEEN=2'b11 until OK.
- In HOLD, pulse P0 again and let sec advance -> NUM stays 7. Assert OK one cycle -> VALID=0, READY_SEEN=0, state ARMED.
- Press P0 only and wait 3 ticks -> TIMEOUT pulses once and READY_SEEN=0. A later P0+P1 round latches normally.
- P1 glitch of 1 cycle (shorter than DEB_CYC) -> no READY_SEEN[1]. A 5-cycle press sets it.
- Last press debounces in a TICK cycle with sec=9 -> NUM=9, not 0. Assert RST during HOLD -> NUM=0 and VALID=0 next cycle.

Source files
------------

// File: rtl/ready_sync_picker.sv
// ready_sync_picker: N-player debounced ready gate that latches a free-running tick counter as the round number.
module ready_sync_picker #(
  parameter int NUM_PLAYERS   = 2,
  parameter int CLK_HZ        = 50_000_000,
  parameter int TICK_HZ       = 1,
  parameter int NUM_MOD       = 10,
  parameter int NUM_W         = 4,
  parameter int DEB_CYC       = 16,
  parameter int TIMEOUT_TICKS = 30
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NUM_PLAYERS-1:0] READY_IN,
  input  logic                   OK,
  output logic                   TICK,
  output logic [NUM_W-1:0]       NUM,
  output logic                   RUN_IN,
  output logic                   VALID,
  output logic [NUM_PLAYERS-1:0] READY_SEEN,
  output logic                   TIMEOUT
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW = $clog2(DIV);
  localparam int DW = DEB_CYC > 1 ? $clog2(DEB_CYC) : 1;
  localparam int TW = TIMEOUT_TICKS > 0 ? $clog2(TIMEOUT_TICKS + 1) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);
  localparam logic [NUM_W-1:0] S_LAST = NUM_W'(NUM_MOD - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEB_CYC > 1 ? DEB_CYC - 1 : 0);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_TICKS > 0 ? TIMEOUT_TICKS - 1 : 0);
  typedef enum logic [1:0] {ARMED, LATCH, HOLD} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [NUM_W-1:0] sec, num_n;
  logic [NUM_PLAYERS-1:0] s1, s2, press, seen_or, seen_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic valid_n;
  assign TICK = cnt == C_LAST;
  always_ff @(posedge CLK)
    if (RST) begin
      cnt <= '0;
      sec <= '0;
    end else begin
      cnt <= TICK ? '0 : cnt + 1'b1;
      if (TICK) sec <= sec == S_LAST ? '0 : sec + 1'b1;
    end
  // Synchroniser is left unreset so a button held through RST still reads high afterwards.
  always_ff @(posedge CLK) begin
    s1 <= READY_IN;
    s2 <= s1;
  end
  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_deb
    logic deb, rel;
    logic [DW-1:0] dcnt;
    assign press[i] = s2[i] & ~deb & rel & (dcnt == D_LAST);
    always_ff @(posedge CLK)
      if (RST) begin
        deb  <= 1'b0;
        rel  <= 1'b0;
        dcnt <= '0;
      end else begin
        rel <= rel | ~s2[i];
        if (s2[i] == deb) dcnt <= '0;
        else if (dcnt == D_LAST) begin
          dcnt <= '0;
          deb  <= s2[i];
        end else dcnt <= dcnt + 1'b1;
      end
  end
  assign seen_or = READY_SEEN | press;
  always_comb begin
    state_n = state;
    seen_n  = READY_SEEN;
    tcnt_n  = tcnt;
    num_n   = NUM;
    valid_n = VALID;
    RUN_IN  = 1'b0;
    TIMEOUT = 1'b0;
    case (state)
      ARMED: begin
        seen_n = seen_or;
        tcnt_n = READY_SEEN == '0 ? '0 : tcnt + TW'(TICK);
        // The round number is captured at the all-ready decision, so a same-cycle tick cannot skew it.
        if (&seen_or) begin
          state_n = LATCH;
          num_n   = sec;
          valid_n = 1'b1;
          tcnt_n  = '0;
        end else if (TIMEOUT_TICKS > 0 && READY_SEEN != '0 && TICK && tcnt == T_LAST) begin
          TIMEOUT = 1'b1;
          seen_n  = '0;
          tcnt_n  = '0;
        end
      end
      LATCH: begin
        RUN_IN  = 1'b1;
        state_n = HOLD;
      end
      HOLD:
        if (OK) begin
          seen_n  = '0;
          valid_n = 1'b0;
          state_n = ARMED;
        end
      default: state_n = ARMED;
    endcase
  end
  always_ff @(posedge CLK)
    if (RST) begin
      state      <= ARMED;
      READY_SEEN <= '0;
      tcnt       <= '0;
      NUM        <= '0;
      VALID      <= 1'b0;
    end else begin
      state      <= state_n;
      READY_SEEN <= seen_n;
      tcnt       <= tcnt_n;
      NUM        <= num_n;
      VALID      <= valid_n;
    end
endmodule

// File: tb/tb_ready_sync_picker.sv
// tb_ready_sync_picker: directed scenarios plus random stimulus checked every cycle against a cycle-count model.
module tb_ready_sync_picker;
  localparam int P = 2, CLK_HZ = 10, TICK_HZ = 1, NUM_MOD = 10, NUM_W = 4, DEB = 2, TO = 3;
  localparam int DIV = CLK_HZ / TICK_HZ;
  logic CLK = 1'b0, RST = 1'b1, OK = 1'b0;
  logic TICK, RUN_IN, VALID, TIMEOUT;
  logic [P-1:0] READY_IN = '0, READY_SEEN;
  logic [NUM_W-1:0] NUM;
  int checks = 0, failures = 0;
  ready_sync_picker #(.NUM_PLAYERS(P), .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .NUM_MOD(NUM_MOD),
    .NUM_W(NUM_W), .DEB_CYC(DEB), .TIMEOUT_TICKS(TO)) dut (
    .CLK(CLK), .RST(RST), .READY_IN(READY_IN), .OK(OK), .TICK(TICK), .NUM(NUM),
    .RUN_IN(RUN_IN), .VALID(VALID), .READY_SEEN(READY_SEEN), .TIMEOUT(TIMEOUT));
  always #5 CLK = ~CLK;
  // Model: a = absolute cycle, c = cycles since reset; divider and sec follow from c arithmetically.
  logic [P-1:0] rq[$];
  int a = 0, c = 0, phase = 0, ticks = 0;
  bit m_ok = 1'b0;
  logic [P-1:0] lvl = '0, rel = '0, seen = '0, press, flip, all_or;
  logic [NUM_W-1:0] m_num = '0;
  logic m_valid = 1'b0, e_tick, e_to;
  int n_tick = 0, n_run = 0, n_to = 0;
  function automatic logic s2(int x, int i);
    return x >= 2 ? rq[x-2][i] : 1'b0;
  endfunction
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, c);
    end
  endtask
  always @(negedge CLK) begin
    e_tick = (c % DIV) == DIV - 1;
    for (int i = 0; i < P; i++) begin
      flip[i] = c >= DEB - 1;
      for (int k = 0; k < DEB; k++) if (s2(a - k, i) == lvl[i]) flip[i] = 1'b0;
    end
    press  = flip & ~lvl & rel;
    all_or = seen | press;
    e_to   = phase == 0 && seen != '0 && all_or != '1 && e_tick && ticks == TO - 1;
    if (m_ok) begin
      chk("TICK", int'(TICK), int'(e_tick));
      chk("RUN_IN", int'(RUN_IN), int'(phase == 1));
      chk("TIMEOUT", int'(TIMEOUT), int'(e_to));
      chk("NUM", int'(NUM), int'(m_num));
      chk("VALID", int'(VALID), int'(m_valid));
      chk("READY_SEEN", int'(READY_SEEN), int'(seen));
      n_tick += int'(TICK);
      n_run  += int'(RUN_IN);
      n_to   += int'(TIMEOUT);
    end
    if (RST) begin
      c = 0; phase = 0; ticks = 0; lvl = '0; rel = '0; seen = '0; m_num = '0; m_valid = 1'b0;
      m_ok = 1'b1;
    end else begin
      for (int i = 0; i < P; i++) if (!s2(a, i)) rel[i] = 1'b1;
      lvl ^= flip;
      case (phase)
        0:
          if (all_or == '1) begin
            m_num = NUM_W'((c / DIV) % NUM_MOD);
            m_valid = 1'b1; phase = 1; seen = all_or; ticks = 0;
          end else if (e_to) begin
            seen = '0; ticks = 0;
          end else begin
            if (seen == '0) ticks = 0;
            else if (e_tick) ticks++;
            seen = all_or;
          end
        1: phase = 2;
        default:
          if (OK) begin
            seen = '0; m_valid = 1'b0; phase = 0;
          end
      endcase
      c++;
    end
    rq.push_back(READY_IN);
    a++;
  end
  task automatic go(int t);
    int g = 0;
    while (c < t && g < 10000) begin
      @(posedge CLK); #1;
      g++;
    end
    if (c < t) begin
      failures++;
      $display("FAIL go: cycle %0d never reached target %0d", c, t);
    end
  endtask
  initial begin
    repeat (4) @(posedge CLK);
    #1 RST = 1'b0;
    go(105);
    chk("idle ticks", n_tick, 10);
    chk("idle NUM", int'(NUM), 0);
    chk("idle VALID", int'(VALID), 0);
    chk("idle runs", n_run, 0);
    go(160); READY_IN[0] = 1'b1;
    go(168); READY_IN[0] = 1'b0;
    go(172); READY_IN[1] = 1'b1;
    go(177);
    chk("r1 NUM", int'(NUM), 7);
    chk("r1 VALID", int'(VALID), 1);
    chk("r1 SEEN", int'(READY_SEEN), 3);
    chk("r1 runs", n_run, 1);
    go(180); READY_IN[1] = 1'b0;
    go(185); READY_IN[0] = 1'b1;
    go(190); READY_IN[0] = 1'b0;
    go(200);
    chk("hold NUM", int'(NUM), 7);
    go(205); OK = 1'b1;
    go(206); OK = 1'b0;
    go(207);
    chk("ack VALID", int'(VALID), 0);
    chk("ack SEEN", int'(READY_SEEN), 0);
    go(210); READY_IN[0] = 1'b1;
    go(216); READY_IN[0] = 1'b0;
    go(241);
    chk("timeouts", n_to, 1);
    chk("timeout SEEN", int'(READY_SEEN), 0);
    go(250); READY_IN = '1;
    go(256); READY_IN = '0;
    go(257);
    chk("r2 NUM", int'(NUM), 5);
    chk("r2 runs", n_run, 2);
    go(260); OK = 1'b1;
    go(261); OK = 1'b0;
    go(270); READY_IN[1] = 1'b1;
    go(271); READY_IN[1] = 1'b0;
    go(280);
    chk("glitch SEEN", int'(READY_SEEN), 0);
    READY_IN[1] = 1'b1;
    go(285); READY_IN[1] = 1'b0;
    go(286);
    chk("press SEEN", int'(READY_SEEN), 2);
    go(380); READY_IN[0] = 1'b1;
    go(396); READY_IN[1] = 1'b1;
    go(401);
    chk("tick NUM", int'(NUM), 9);
    chk("tick VALID", int'(VALID), 1);
    go(405); RST = 1'b1;
    @(posedge CLK); #1;
    chk("rst NUM", int'(NUM), 0);
    chk("rst VALID", int'(VALID), 0);
    RST = 1'b0;
    go(20);
    chk("held SEEN", int'(READY_SEEN), 0);
    READY_IN = '0;
    go(25); READY_IN[0] = 1'b1;
    go(30); READY_IN[0] = 1'b0;
    go(32);
    chk("repress SEEN", int'(READY_SEEN), 1);
    for (int n = 0; n < 4000; n++) begin
      @(posedge CLK); #1;
      for (int i = 0; i < P; i++) if ($urandom_range(0, 19) == 0) READY_IN[i] = ~READY_IN[i];
      if ($urandom_range(0, 9) == 0) OK = ~OK;
      RST = $urandom_range(0, 999) == 0;
    end
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
